// File: rtl/red_pipe_pkg.sv
// red_pkg: shared defaults, derived-width helpers and lane mode encoding for red_pipe
package red_pkg;
    localparam int LANE_W_D = 8;
    localparam int LANES_D = 2;
    localparam int OUT_W_D = 16;
    localparam logic RED_SIGNED = 1'b0;
    localparam logic RED_UNSIGNED = 1'b1;
    function automatic int full_w(int lane_w, int lanes);
        return lane_w + 1 + $clog2(lanes);
    endfunction
    function automatic int stages(int lanes);
        return 1 + $clog2(lanes);
    endfunction
endpackage

// File: rtl/red_pipe_if.sv
// red_pipe_if: valid/ready request and result bundle of the reduction unit
//   master: drives in_valid, rs, rt, uns, out_ready; observes in_ready, out_valid, rd
//   slave:  the reduction unit (opposite directions)
interface red_pipe_if import red_pkg::*; #(
    parameter int LANE_W = LANE_W_D,
    parameter int LANES = LANES_D,
    parameter int OUT_W = OUT_W_D
);
    logic in_valid, in_ready, uns, out_valid, out_ready;
    logic [LANES*LANE_W-1:0] rs, rt;
    logic [OUT_W-1:0] rd;
    modport master (output in_valid, rs, rt, uns, out_ready, input in_ready, out_valid, rd);
    modport slave (input in_valid, rs, rt, uns, out_ready, output in_ready, out_valid, rd);
endinterface

// File: rtl/red_pipe_stage.sv
// red_pipe_stage: one pipeline register level holding valid, mode and partial sums
//   clk, rst (async, active-high); load: capture in_v/in_u/in_d; advance: contents leave
//   v, u, d: registered valid, lane mode and data
module red_pipe_stage import red_pkg::*; #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         advance,
    input  logic         in_v,
    input  logic         in_u,
    input  logic [W-1:0] in_d,
    output logic         v,
    output logic         u,
    output logic [W-1:0] d
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            u <= RED_SIGNED;
            d <= '0;
        end else if (load) begin
            v <= in_v;
            u <= in_u;
            d <= in_d;
        end else if (advance) begin
            v <= 1'b0;
        end
    end
endmodule

// File: rtl/red_pipe.sv
// red_pipe: pipelined signed/unsigned lane reduction rd = sum(rs[i] + rt[i])
//   clk, rst (async, active-high); bus: red_pipe_if.slave (in_valid/in_ready/rs/rt/uns,
//   out_valid/out_ready/rd). Define RED_PIPE_SAT_EN to saturate rd when OUT_W < FULL_W.
module red_pipe import red_pkg::*; #(
    parameter int LANE_W = LANE_W_D,
    parameter int LANES = LANES_D,
    parameter int OUT_W = OUT_W_D
) (
    input  logic      clk,
    input  logic      rst,
    red_pipe_if.slave bus
);
    localparam int FW = full_w(LANE_W, LANES);
    localparam int ST = stages(LANES);
    localparam int TW = FW * (2 * LANES - 1);
    // Every stage is packed back to back into one flat bus, stage 0 at the bottom.
    function automatic int off(int n);
        return FW * (2 * LANES - 2 * (LANES >> n));
    endfunction
    function automatic logic [FW-1:0] ext(logic [LANE_W-1:0] x, logic m);
        return {{(FW - LANE_W){(m == RED_SIGNED) && x[LANE_W-1]}}, x};
    endfunction
    logic [TW-1:0] dn, dq;
    logic [ST-1:0] v, u, adv;
    logic [ST:0] rdy;
    logic [FW-1:0] s;
    logic su;
    // Ready ripples back from the consumer so a full pipe still accepts while draining.
    always_comb begin
        adv = '0;
        rdy = '0;
        rdy[ST] = bus.out_ready;
        for (int k = ST - 1; k >= 0; k--) begin
            adv[k] = v[k] && rdy[k+1];
            rdy[k] = !v[k] || adv[k];
        end
    end
    for (genvar k = 0; k < ST; k++) begin : g_st
        localparam int OF = off(k);
        localparam int CW = (LANES >> k) * FW;
        logic iv, iu;
        if (k == 0) begin : g_in
            assign iv = bus.in_valid;
            assign iu = bus.uns;
            for (genvar i = 0; i < LANES; i++) begin : g_l
                assign dn[i*FW +: FW] = ext(bus.rs[i*LANE_W +: LANE_W], bus.uns)
                                      + ext(bus.rt[i*LANE_W +: LANE_W], bus.uns);
            end
        end else begin : g_tree
            localparam int PO = off(k - 1);
            assign iv = v[k-1];
            assign iu = u[k-1];
            for (genvar j = 0; j < (LANES >> k); j++) begin : g_l
                assign dn[OF + j*FW +: FW] = dq[PO + 2*j*FW +: FW] + dq[PO + (2*j+1)*FW +: FW];
            end
        end
        red_pipe_stage #(.W(CW)) u_stage (
            .clk(clk), .rst(rst), .load(rdy[k]), .advance(adv[k]),
            .in_v(iv), .in_u(iu), .in_d(dn[OF +: CW]),
            .v(v[k]), .u(u[k]), .d(dq[OF +: CW])
        );
    end
    assign s = dq[TW-1 -: FW];
    assign su = u[ST-1];
    assign bus.in_ready = !rst && rdy[0];
    assign bus.out_valid = v[ST-1];
`ifdef RED_PIPE_SAT_EN
    if (OUT_W < FW) begin : g_sat
        localparam logic [OUT_W-1:0] SMIN = OUT_W'(1) << (OUT_W - 1);
        // Signed fits when the dropped bits and the new sign bit all agree.
        assign bus.rd = (su == RED_UNSIGNED)
                      ? (~|s[FW-1:OUT_W] ? s[OUT_W-1:0] : '1)
                      : ((&s[FW-1:OUT_W-1] || ~|s[FW-1:OUT_W-1]) ? s[OUT_W-1:0]
                         : (s[FW-1] ? SMIN : ~SMIN));
    end else begin : g_ext
        assign bus.rd = (su == RED_UNSIGNED) ? OUT_W'(s) : OUT_W'($signed(s));
    end
`else
    assign bus.rd = (su == RED_UNSIGNED) ? OUT_W'(s) : OUT_W'($signed(s));
`endif
endmodule

// File: tb/tb_red_pipe.sv
// tb_red_pipe: randomized and directed self-checking bench for red_pipe
module tb_red_pipe;
    import red_pkg::*;
`ifdef RED_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    int tests = 0;
    int fails = 0;
    always #5 clk = ~clk;
    red_pipe_if #(.LANE_W(8), .LANES(2), .OUT_W(16)) b0 ();
    red_pipe_if #(.LANE_W(8), .LANES(2), .OUT_W(8)) b1 ();
    red_pipe_if #(.LANE_W(8), .LANES(4), .OUT_W(16)) b2 ();
    red_pipe #(.LANE_W(8), .LANES(2), .OUT_W(16)) d0 (.clk(clk), .rst(rst), .bus(b0));
    red_pipe #(.LANE_W(8), .LANES(2), .OUT_W(8)) d1 (.clk(clk), .rst(rst), .bus(b1));
    red_pipe #(.LANE_W(8), .LANES(4), .OUT_W(16)) d2 (.clk(clk), .rst(rst), .bus(b2));

    // Exact mathematical sum of all lanes of both operands.
    function automatic int lsum(logic [31:0] a, logic [31:0] b, int lanes, logic m);
        int s = 0;
        for (int i = 0; i < lanes; i++) begin
            logic [7:0] x, y;
            x = a[i*8 +: 8];
            y = b[i*8 +: 8];
            s += m ? int'(x) + int'(y) : int'($signed(x)) + int'($signed(y));
        end
        return s;
    endfunction

    function automatic logic [7:0] fit8(int s, logic m);
        if (SAT && m && s > 255) return 8'hFF;
        if (SAT && !m && s > 127) return 8'h7F;
        if (SAT && !m && s < -128) return 8'h80;
        return 8'(s);
    endfunction

    task automatic idle();
        b0.in_valid = 0; b0.out_ready = 1;
        b1.in_valid = 0; b1.out_ready = 1;
        b2.in_valid = 0; b2.out_ready = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        b0.rs = '0; b0.rt = '0; b0.uns = 0;
        b1.rs = '0; b1.rt = '0; b1.uns = 0;
        b2.rs = '0; b2.rt = '0; b2.uns = 0;
        @(negedge clk);
        #1;
        tests++;
        if (b0.in_ready !== 1'b0 || b0.out_valid !== 1'b0 || b0.rd !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b rd=%h want 0 0 0000", b0.in_ready, b0.out_valid, b0.rd);
        end
        tests++;
        if (b2.in_ready !== 1'b0 || b2.out_valid !== 1'b0 || b2.rd !== 16'h0) begin
            fails++;
            $display("FAIL reset_state4: in_ready=%b out_valid=%b rd=%h want 0 0 0000", b2.in_ready, b2.out_valid, b2.rd);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if (b0.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b want 1", b0.in_ready);
        end
    endtask

    task automatic test_signed();
        @(negedge clk);
        b0.rs = 16'h7F7F; b0.rt = 16'h7F7F; b0.uns = RED_SIGNED; b0.in_valid = 1;
        #1;
        tests++;
        if (b0.in_ready !== 1'b1) begin fails++; $display("FAIL sig_accept: in_ready=%b want 1", b0.in_ready); end
        @(negedge clk);
        b0.in_valid = 0;
        #1;
        tests++;
        if (b0.out_valid !== 1'b0) begin fails++; $display("FAIL sig_early: out_valid=%b want 0", b0.out_valid); end
        @(negedge clk);
        #1;
        tests++;
        if (b0.out_valid !== 1'b1 || b0.rd !== 16'h01FC) begin
            fails++;
            $display("FAIL sig_result: out_valid=%b rd=%h want 1 01fc", b0.out_valid, b0.rd);
        end
        @(negedge clk);
    endtask

    task automatic test_negative();
        logic [15:0] exp [2] = '{16'hFE00, 16'h0200};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            b0.rs = 16'h8080; b0.rt = 16'h8080;
            b0.uns = (c == 1) ? RED_UNSIGNED : RED_SIGNED;
            b0.in_valid = (c < 2);
            #1;
            if (c < 2) begin
                tests++;
                if (b0.in_ready !== 1'b1) begin fails++; $display("FAIL neg_accept%0d: in_ready=%b want 1", c, b0.in_ready); end
            end
            tests++;
            if (c >= 2 && c < 4) begin
                if (b0.out_valid !== 1'b1 || b0.rd !== exp[c-2]) begin
                    fails++;
                    $display("FAIL neg_result%0d: out_valid=%b rd=%h want 1 %h", c - 2, b0.out_valid, b0.rd, exp[c-2]);
                end
            end else if (b0.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL neg_idle%0d: out_valid=%b want 0", c, b0.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] q [$];
        logic [15:0] held = '0;
        bit stall = 0;
        int sent = 0, got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            b0.out_ready = (c >= 3);
            b0.in_valid = (sent < 4);
            b0.rs = {8'(sent * 37 + 5), 8'(sent * 91 + 200)};
            b0.rt = {8'(sent * 13 + 130), 8'(sent * 7 + 60)};
            b0.uns = sent[0];
            #1;
            if (c == 2) begin
                tests++;
                if (b0.in_ready !== 1'b0 || sent != 2) begin
                    fails++;
                    $display("FAIL bp_full: in_ready=%b accepts=%0d want 0 2", b0.in_ready, sent);
                end
            end
            if (stall) begin
                tests++;
                if (b0.out_valid !== 1'b1 || b0.rd !== held) begin
                    fails++;
                    $display("FAIL bp_hold: out_valid=%b rd=%h want 1 %h", b0.out_valid, b0.rd, held);
                end
            end
            if (b0.out_valid === 1'b1 && b0.out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: rd=%h with nothing outstanding", b0.rd);
                end else if (b0.rd !== q[0]) begin
                    fails++;
                    $display("FAIL bp_order%0d: rd=%h want %h", got, b0.rd, q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            stall = (b0.out_valid === 1'b1) && !b0.out_ready;
            held = b0.rd;
            if (b0.in_valid && b0.in_ready === 1'b1) begin
                q.push_back(16'(lsum(32'(b0.rs), 32'(b0.rt), 2, b0.uns)));
                sent++;
            end
        end
        tests++;
        if (got != 4) begin fails++; $display("FAIL bp_count: results=%0d want 4", got); end
        idle();
    endtask

    task automatic test_narrow();
        logic [15:0] rs_t [3] = '{16'h7F7F, 16'h8080, 16'h8080};
        logic u_t [3] = '{RED_SIGNED, RED_SIGNED, RED_UNSIGNED};
        logic [7:0] exp_t [3];
        logic [7:0] q [$];
        exp_t[0] = SAT ? 8'h7F : 8'hFC;
        exp_t[1] = SAT ? 8'h80 : 8'h00;
        exp_t[2] = SAT ? 8'hFF : 8'h00;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            b1.in_valid = (c < 43);
            b1.rs = (c < 3) ? rs_t[c] : 16'($urandom);
            b1.rt = (c < 3) ? rs_t[c] : 16'($urandom);
            b1.uns = (c < 3) ? u_t[c] : 1'($urandom_range(0, 1));
            #1;
            if (c >= 2) begin
                tests++;
                if (b1.out_valid !== 1'b1 || q.size() == 0 || b1.rd !== q[0]) begin
                    fails++;
                    $display("FAIL narrow%0d: out_valid=%b rd=%h want 1 %h", c - 2, b1.out_valid, b1.rd, q.size() ? q[0] : 8'h0);
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (b1.in_valid && b1.in_ready === 1'b1)
                q.push_back((c < 3) ? exp_t[c] : fit8(lsum(32'(b1.rs), 32'(b1.rt), 2, b1.uns), b1.uns));
        end
        idle();
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        b0.out_ready = 0; b0.in_valid = 1; b0.rs = 16'h1234; b0.rt = 16'h0101; b0.uns = RED_SIGNED;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_full: out_valid=%b in_ready=%b want 1 0", b0.out_valid, b0.in_ready);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if (b0.out_valid !== 1'b0 || b0.in_ready !== 1'b0 || b0.rd !== 16'h0) begin
            fails++;
            $display("FAIL mid_async: out_valid=%b in_ready=%b rd=%h want 0 0 0000", b0.out_valid, b0.in_ready, b0.rd);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        tests++;
        if (b0.in_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: in_ready=%b want 1", b0.in_ready); end
        for (int c = 0; c < 4; c++) begin
            tests++;
            if (b0.out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale%0d: out_valid=%b want 0", c, b0.out_valid); end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_latency();
        int lat = -1;
        logic [15:0] exp;
        @(negedge clk);
        b2.rs = 32'h80FF_017F; b2.rt = 32'hFF80_7F01; b2.uns = RED_SIGNED; b2.in_valid = 1;
        exp = 16'(lsum(b2.rs, b2.rt, 4, b2.uns));
        for (int c = 1; c <= 10 && lat < 0; c++) begin
            @(negedge clk);
            b2.in_valid = 0;
            #1;
            if (b2.out_valid === 1'b1) lat = c;
        end
        tests++;
        if (lat != 3 || b2.rd !== exp) begin
            fails++;
            $display("FAIL latency4: cycles=%0d rd=%h want 3 %h", lat, b2.rd, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] q [$];
        logic [15:0] held = '0;
        bit stall = 0;
        int sent = 0, got = 0;
        for (int c = 0; c < 5000 && got < 500; c++) begin
            @(negedge clk);
            b2.in_valid = (sent < 500) && ($urandom_range(0, 3) != 0);
            b2.rs = $urandom;
            b2.rt = $urandom;
            b2.uns = 1'($urandom_range(0, 1));
            b2.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall) begin
                tests++;
                if (b2.out_valid !== 1'b1 || b2.rd !== held) begin
                    fails++;
                    $display("FAIL rnd_hold: out_valid=%b rd=%h want 1 %h", b2.out_valid, b2.rd, held);
                end
            end
            if (b2.out_valid === 1'b1 && b2.out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_extra: rd=%h with nothing outstanding", b2.rd);
                end else if (b2.rd !== q[0]) begin
                    fails++;
                    $display("FAIL rnd_data%0d: rd=%h want %h", got, b2.rd, q[0]);
                end
                if (q.size() != 0) void'(q.pop_front());
                got++;
            end
            stall = (b2.out_valid === 1'b1) && !b2.out_ready;
            held = b2.rd;
            if (b2.in_valid && b2.in_ready === 1'b1) begin
                q.push_back(16'(lsum(b2.rs, b2.rt, 4, b2.uns)));
                sent++;
            end
        end
        tests++;
        if (got != 500) begin fails++; $display("FAIL rnd_count: results=%0d want 500", got); end
        idle();
    endtask

    initial begin
        test_reset();
        test_signed();
        test_negative();
        test_backpressure();
        test_narrow();
        test_latency();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
